// File: rtl/noc_crossbar.sv
// noc_crossbar: per-router switch-traversal crossbar.
// Each output independently selects one input flit (multicast allowed).
// Out-of-range selects produce the all-zero flit.
// Optional output register stage: define CROSSBAR_OUT_REG_EN to add one
// flop stage with 1-cycle latency and synchronous active-high reset.
// Without the macro the block is a purely combinational mux and clk/rst
// are unused.

package noc_params;
    localparam int VC_SIZE          = 4;
    localparam int DEST_ADDR_SIZE_X = 4;
    localparam int DEST_ADDR_SIZE_Y = 4;
    localparam int HEAD_PL_SIZE     = 20;
    localparam int FLIT_DATA_SIZE   = VC_SIZE + DEST_ADDR_SIZE_X
                                    + DEST_ADDR_SIZE_Y + HEAD_PL_SIZE;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;

    typedef struct packed {
        logic [VC_SIZE-1:0]          vc_id;
        logic [DEST_ADDR_SIZE_X-1:0] x_dest;
        logic [DEST_ADDR_SIZE_Y-1:0] y_dest;
        logic [HEAD_PL_SIZE-1:0]     head_pl;
    } head_data_t;

    typedef union packed {
        head_data_t                head_data;
        logic [FLIT_DATA_SIZE-1:0] bt_pl;
    } flit_data_t;

    typedef struct packed {
        flit_label_t flit_label;
        flit_data_t  data;
    } flit_t;
endpackage

module noc_crossbar
    import noc_params::*;
#(
    parameter  int INPUT_NUM  = 4,
    parameter  int OUTPUT_NUM = 4,
    localparam int SEL_SIZE   = $clog2(INPUT_NUM)
) (
    input  logic                clk,
    input  logic                rst,
    input  flit_t               data_i [INPUT_NUM],
    input  logic [SEL_SIZE-1:0] sel_i  [OUTPUT_NUM],
    output flit_t               data_o [OUTPUT_NUM]
);

    // Reject configurations the select encoding cannot represent.
    if (INPUT_NUM < 2) begin : g_bad_inputs
        $error("noc_crossbar: INPUT_NUM must be >= 2");
    end
    if (OUTPUT_NUM < 1) begin : g_bad_outputs
        $error("noc_crossbar: OUTPUT_NUM must be >= 1");
    end

    flit_t data_d [OUTPUT_NUM];

    // Per-output AND-OR mux: an output takes input i only on an exact
    // select match, so unused select codes (and X selects) yield zero.
    always_comb begin
        for (int o = 0; o < OUTPUT_NUM; o++) begin
            // NOTE: assign a default before any conditional update so every
            // path writes data_d and no latch is inferred.
            data_d[o] = '0;
            for (int i = 0; i < INPUT_NUM; i++) begin
                if (sel_i[o] == SEL_SIZE'(i)) begin
                    data_d[o] = data_i[i];
                end
            end
        end
    end

`ifdef CROSSBAR_OUT_REG_EN
    flit_t data_q [OUTPUT_NUM];

    // Output register: capture the muxed flits every edge, clear on reset.
    always_ff @(posedge clk) begin
        for (int o = 0; o < OUTPUT_NUM; o++) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            if (rst) begin
                data_q[o] <= '0;
            end else begin
                data_q[o] <= data_d[o];
            end
        end
    end

    assign data_o = data_q;
`else
    // clk and rst have no function in the combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign data_o = data_d;
`endif

endmodule

// File: tb/tb_noc_crossbar.sv
// tb_noc_crossbar: directed test of noc_crossbar in a 4x4 and a 3x2
// configuration, with a behavioural routing model compared every cycle
// plus literal expectations. Works with or without CROSSBAR_OUT_REG_EN.

module tb_noc_crossbar;
    import noc_params::*;

    logic  clk;
    logic  rst;

    flit_t      din   [4];
    logic [1:0] sel   [4];
    flit_t      dout  [4];

    flit_t      din3  [3];
    logic [1:0] sel3  [2];
    flit_t      dout3 [2];

    int total_cnt;
    int pass_cnt;
    bit cmp_en;

    noc_crossbar #(.INPUT_NUM(4), .OUTPUT_NUM(4)) u_dut4 (
        .clk    (clk),
        .rst    (rst),
        .data_i (din),
        .sel_i  (sel),
        .data_o (dout)
    );

    noc_crossbar #(.INPUT_NUM(3), .OUTPUT_NUM(2)) u_dut3 (
        .clk    (clk),
        .rst    (rst),
        .data_i (din3),
        .sel_i  (sel3),
        .data_o (dout3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input flit_t act, input flit_t exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic flit_t mk(flit_label_t l, int vc, int x, int y, int pl);
        flit_t f;
        f.flit_label             = l;
        f.data.head_data.vc_id   = 4'(vc);
        f.data.head_data.x_dest  = 4'(x);
        f.data.head_data.y_dest  = 4'(y);
        f.data.head_data.head_pl = 20'(pl);
        return f;
    endfunction

    function automatic flit_t mk_body(logic [31:0] pl);
        flit_t f;
        f.flit_label = BODY;
        f.data.bt_pl = pl;
        return f;
    endfunction

    // Routing rule: output takes the selected input, zero if no such input.
    function automatic flit_t route4(int o);
        int s = int'(sel[o]);
        return (s < 4) ? din[s] : flit_t'('0);
    endfunction

    function automatic flit_t route3(int o);
        int s = int'(sel3[o]);
        return (s < 3) ? din3[s] : flit_t'('0);
    endfunction

`ifdef CROSSBAR_OUT_REG_EN
    flit_t exp4 [4];
    flit_t exp3 [2];

    // Model of the registered build: one edge of delay, zero under reset.
    always @(posedge clk) begin
        for (int o = 0; o < 4; o++) exp4[o] = rst ? flit_t'('0) : route4(o);
        for (int o = 0; o < 2; o++) exp3[o] = rst ? flit_t'('0) : route3(o);
    end

    function automatic flit_t model4(int o);
        return exp4[o];
    endfunction
    function automatic flit_t model3(int o);
        return exp3[o];
    endfunction
`else
    function automatic flit_t model4(int o);
        return route4(o);
    endfunction
    function automatic flit_t model3(int o);
        return route3(o);
    endfunction
`endif

    // Compare DUT outputs against the model once per cycle, away from posedge.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int o = 0; o < 4; o++) check($sformatf("model4[%0d]", o), dout[o], model4(o));
            for (int o = 0; o < 2; o++) check($sformatf("model3[%0d]", o), dout3[o], model3(o));
        end
    end

    // Inputs change just after a rising edge.
    task automatic drive_slot();
        @(posedge clk);
        #1;
    endtask

    // Wait until outputs reflect the inputs just driven.
    task automatic settle();
`ifdef CROSSBAR_OUT_REG_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
    endtask

    task automatic set_sel(int a, int b, int c, int d);
        sel[0] = 2'(a);
        sel[1] = 2'(b);
        sel[2] = 2'(c);
        sel[3] = 2'(d);
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        cmp_en    = 1'b0;
        rst       = 1'b1;
        for (int i = 0; i < 4; i++) din[i]  = '0;
        for (int i = 0; i < 3; i++) din3[i] = '0;
        set_sel(0, 0, 0, 0);
        sel3[0] = 2'd0;
        sel3[1] = 2'd0;

        // Reset state: all outputs zero.
        repeat (2) @(posedge clk);
        #1;
        for (int o = 0; o < 4; o++) check("reset4", dout[o], '0);
        for (int o = 0; o < 2; o++) check("reset3", dout3[o], '0);
        rst    = 1'b0;
        cmp_en = 1'b1;

        // Identity mapping, one distinguished input at a time.
        for (int j = 0; j < 4; j++) begin
            drive_slot();
            for (int i = 0; i < 4; i++) din[i] = (i == j) ? mk(HEAD, 1, 1, 1, 1) : mk(HEAD, 10, 10, 10, 10);
            set_sel(0, 1, 2, 3);
            settle();
            for (int i = 0; i < 4; i++)
                check($sformatf("identity j=%0d o=%0d", j, i), dout[i],
                      (i == j) ? mk(HEAD, 1, 1, 1, 1) : mk(HEAD, 10, 10, 10, 10));
        end

        // Permutation {3,0,2,1} with head_pl = k+1.
        drive_slot();
        for (int k = 0; k < 4; k++) din[k] = mk(HEAD, k, 0, 0, k + 1);
        set_sel(3, 0, 2, 1);
        settle();
        check("perm o0", dout[0], mk(HEAD, 3, 0, 0, 4));
        check("perm o1", dout[1], mk(HEAD, 0, 0, 0, 1));
        check("perm o2", dout[2], mk(HEAD, 2, 0, 0, 3));
        check("perm o3", dout[3], mk(HEAD, 1, 0, 0, 2));

        // Multicast of a BODY flit from input 2, plus out-of-range on 3x2.
        drive_slot();
        din[2] = mk_body(32'hDEAD_BEEF);
        set_sel(2, 2, 2, 2);
        din3[0] = mk(TAIL, 7, 7, 7, 7);
        din3[1] = mk(HEADTAIL, 9, 8, 7, 6);
        din3[2] = mk(BODY, 5, 5, 5, 5);
        sel3[0] = 2'd3;
        sel3[1] = 2'd1;
        settle();
        for (int o = 0; o < 4; o++) check($sformatf("mcast o%0d", o), dout[o], mk_body(32'hDEAD_BEEF));
        check("oor o0", dout3[0], '0);
        check("oor o1", dout3[1], mk(HEADTAIL, 9, 8, 7, 6));

        // New mapping: latency check (old value holds until the next edge
        // in the registered build, immediate in the combinational build).
        drive_slot();
        for (int k = 0; k < 4; k++) din[k] = mk(TAIL, 2, 3, 4, 100 + k);
        set_sel(1, 1, 0, 3);
        sel3[0] = 2'd2;
        sel3[1] = 2'd3;
        #1;
`ifdef CROSSBAR_OUT_REG_EN
        check("latency hold o0", dout[0], mk_body(32'hDEAD_BEEF));
        check("latency hold oor", dout3[0], '0);
`else
        check("latency comb o0", dout[0], mk(TAIL, 2, 3, 4, 101));
        check("latency comb o3", dout3[0], mk(BODY, 5, 5, 5, 5));
`endif
        settle();
        check("latency new o0", dout[0], mk(TAIL, 2, 3, 4, 101));
        check("latency new o2", dout[2], mk(TAIL, 2, 3, 4, 100));
        check("latency new 3x2 o0", dout3[0], mk(BODY, 5, 5, 5, 5));
        check("latency new 3x2 o1", dout3[1], '0);

        // Reset mid-stream with nonzero traffic.
        drive_slot();
        for (int k = 0; k < 4; k++) din[k] = mk(HEAD, 5, 6, 7, 8 + k);
        set_sel(0, 1, 2, 3);
        sel3[0] = 2'd0;
        sel3[1] = 2'd2;
        settle();
        drive_slot();
        rst = 1'b1;
        drive_slot();
`ifdef CROSSBAR_OUT_REG_EN
        for (int o = 0; o < 4; o++) check("rst edge1", dout[o], '0);
`else
        for (int o = 0; o < 4; o++) check("rst ignored", dout[o], mk(HEAD, 5, 6, 7, 8 + o));
`endif
        // Inputs change while reset holds; nothing may leak through.
        for (int k = 0; k < 4; k++) din[k] = mk(BODY, 1, 2, 3, 40 + k);
        set_sel(3, 2, 1, 0);
        drive_slot();
`ifdef CROSSBAR_OUT_REG_EN
        for (int o = 0; o < 4; o++) check("rst edge2", dout[o], '0);
        for (int o = 0; o < 2; o++) check("rst edge2 3x2", dout3[o], '0);
`else
        check("rst ignored new", dout[0], mk(BODY, 1, 2, 3, 43));
`endif
        rst = 1'b0;
        drive_slot();
        check("post rst o0", dout[0], mk(BODY, 1, 2, 3, 43));
        check("post rst o3", dout[3], mk(BODY, 1, 2, 3, 40));
        check("post rst 3x2 o0", dout3[0], mk(TAIL, 7, 7, 7, 7));

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
